// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-masked writes, write-to-read bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle clear sequencer.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wmask,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata
);

    localparam int                NB    = DATA_W / 8;
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZADDR = {ADDR_W{1'b0}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_wr_acc;
    logic [DATA_W-1:0]   w_wr_merged;

    function automatic logic [DATA_W-1:0] f_byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     mask
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Write qualification: clear_req in the same cycle wins and drops the write.
    always_comb begin
        w_wr_acc = (r_state == ST_IDLE) && we && !clear_req && (|wmask)
                   && !((ZERO_REG != 0) && (waddr == ZADDR));
        w_wr_merged = f_byte_merge(r_mem[waddr], wdata, wmask);
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_clr_cnt;
        w_ready_nxt = r_ready;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_clr_nxt   = ZADDR;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_clr_nxt   = r_clr_cnt + ONE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_nxt   = ZADDR;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_clr_nxt   = ZADDR;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= ZADDR;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Storage array: contents deliberately survive reset; the clear sequence zeroes them.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= {DATA_W{1'b0}};
        end else if (w_wr_acc) begin
            r_mem[waddr] <= w_wr_merged;
        end
    end

    assign ready = r_ready;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[g*ADDR_W +: ADDR_W];

        // Read mux: zero entry beats bypass, bypass beats array contents.
        always_comb begin
            w_rd = {DATA_W{1'b0}};
            if (!r_ready) begin
                w_rd = {DATA_W{1'b0}};
            end else if ((ZERO_REG != 0) && (w_ra == ZADDR)) begin
                w_rd = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && w_wr_acc && (w_ra == waddr)) begin
                w_rd = w_wr_merged;
            end else begin
                w_rd = r_mem[w_ra];
            end
        end

        assign rdata[g*DATA_W +: DATA_W] = w_rd;
    end

endmodule
